// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared types and helpers for the 2x2 pooling path.
// The compare helper is reused by later pooling and ReLU stages.
package maxpool_2x2_stream_pkg;

  localparam int unsigned DefImgWidth  = 7;
  localparam int unsigned DefImgHeight = 7;
  localparam int unsigned DefDatawidth = 16;

  // Operands are widened to this size (sign- or zero-extended) before comparing.
  localparam int unsigned MaxDataW = 64;

  typedef logic [MaxDataW-1:0] cmp_word_t;

  // Parity of a column or row index inside a 2x2 window.
  typedef enum logic {
    PhaseEven = 1'b0,
    PhaseOdd  = 1'b1
  } pair_phase_e;

  // Counter width that stays legal for a one-entry range.
  function automatic int unsigned cnt_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Max selector: 1 picks a, 0 picks b.
  function automatic logic max_sel_a(cmp_word_t a, cmp_word_t b, logic is_signed);
    if (is_signed) begin
      return $signed(a) > $signed(b);
    end
    return a > b;
  endfunction

endpackage

// File: rtl/maxpool_2x2_stream_if.sv
// Pixel stream bundle between the convolution stage and the pooling stage.
interface maxpool_2x2_stream_if
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int unsigned Datawidth = DefDatawidth
) ();

  logic                 Valid_IN;
  logic [Datawidth-1:0] In;
  logic                 Valid_OUT;
  logic [Datawidth-1:0] Out;
  logic                 Frame_Done;

  modport master (
    output Valid_IN,
    output In,
    input  Valid_OUT,
    input  Out,
    input  Frame_Done
  );

  modport slave (
    input  Valid_IN,
    input  In,
    output Valid_OUT,
    output Out,
    output Frame_Done
  );

endinterface

// File: rtl/maxpool_2x2_stream_pool_row_buffer.sv
// Row of horizontal pair maxima: synchronous write, combinational read.
module maxpool_2x2_stream_pool_row_buffer
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int unsigned Depth = 3,
  parameter int unsigned Width = DefDatawidth,
  parameter int unsigned AddrW = cnt_w(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  // No reset: every entry is written on an even row before the odd row reads it.
  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pool over a raster pixel stream.
// Even rows park pair maxima in the row buffer; odd rows combine and emit.
module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int unsigned IMG_Width  = DefImgWidth,
  parameter int unsigned IMG_Height = DefImgHeight,
  parameter int unsigned Datawidth  = DefDatawidth,
  parameter bit          Signed     = 1'b0
) (
  input logic CLK,
  input logic CLR,
  maxpool_2x2_stream_if.slave bus
);

  localparam int unsigned COL_W  = cnt_w(IMG_Width);
  localparam int unsigned ROW_W  = cnt_w(IMG_Height);
  localparam int unsigned OUT_W  = IMG_Width / 2;
  localparam int unsigned OUT_H  = IMG_Height / 2;
  localparam int unsigned BUF_AW = cnt_w(OUT_W);

  localparam logic [COL_W-1:0] ColLast     = COL_W'(IMG_Width - 1);
  localparam logic [ROW_W-1:0] RowLast     = ROW_W'(IMG_Height - 1);
  localparam logic [COL_W-1:0] ColPairLast = COL_W'(2 * OUT_W - 1);
  localparam logic [ROW_W-1:0] RowPairLast = ROW_W'(2 * OUT_H - 1);
  localparam bit               WidthOdd    = (IMG_Width % 2) == 1;
  localparam bit               HeightOdd   = (IMG_Height % 2) == 1;

  logic [COL_W-1:0]     cot_q, cot_d;
  logic [ROW_W-1:0]     hang_q, hang_d;
  logic [Datawidth-1:0] hold_q, hold_d;
  logic [Datawidth-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;

  logic                 col_last, row_last;
  logic                 col_in, row_in;
  pair_phase_e          col_phase, row_phase;
  logic [Datawidth-1:0] pm, vmax;
  logic                 rb_we;
  logic [BUF_AW-1:0]    rb_addr;
  logic [Datawidth-1:0] rb_rdata;

  function automatic cmp_word_t ext(logic [Datawidth-1:0] v);
    cmp_word_t w;
    w = Signed ? {MaxDataW{v[Datawidth-1]}} : '0;
    w[Datawidth-1:0] = v;
    return w;
  endfunction

  assign col_last  = (cot_q == ColLast);
  assign row_last  = (hang_q == RowLast);
  // A trailing odd column/row is counted but never touches hold or the buffer.
  assign col_in    = !(WidthOdd && col_last);
  assign row_in    = !(HeightOdd && row_last);
  assign col_phase = pair_phase_e'(cot_q[0]);
  assign row_phase = pair_phase_e'(hang_q[0]);
  assign rb_addr   = BUF_AW'(cot_q >> 1);

  assign pm   = max_sel_a(ext(hold_q), ext(bus.In), Signed) ? hold_q : bus.In;
  assign vmax = max_sel_a(ext(rb_rdata), ext(pm), Signed) ? rb_rdata : pm;

  always_comb begin
    cot_d   = cot_q;
    hang_d  = hang_q;
    hold_d  = hold_q;
    out_d   = out_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    rb_we   = 1'b0;
    if (bus.Valid_IN) begin
      if (col_last) begin
        cot_d  = '0;
        hang_d = row_last ? '0 : hang_q + 1'b1;
      end else begin
        cot_d = cot_q + 1'b1;
      end
      if (col_in) begin
        unique case (col_phase)
          PhaseEven: hold_d = bus.In;
          PhaseOdd: begin
            if (row_in) begin
              unique case (row_phase)
                PhaseEven: rb_we = 1'b1;
                PhaseOdd: begin
                  out_d   = vmax;
                  valid_d = 1'b1;
                  done_d  = (cot_q == ColPairLast) && (hang_q == RowPairLast);
                end
                default: ;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cot_q   <= '0;
      hang_q  <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cot_q   <= cot_d;
      hang_q  <= hang_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  maxpool_2x2_stream_pool_row_buffer #(
    .Depth (OUT_W),
    .Width (Datawidth),
    .AddrW (BUF_AW)
  ) u_row_buffer (
    .clk_i   (CLK),
    .we_i    (rb_we),
    .waddr_i (rb_addr),
    .wdata_i (pm),
    .raddr_i (rb_addr),
    .rdata_o (rb_rdata)
  );

  assign bus.Valid_OUT  = valid_q;
  assign bus.Out        = out_q;
  assign bus.Frame_Done = done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Bench for maxpool_2x2_stream: four instances (4x4, 7x7, 2x2 signed/unsigned)
// share one broadcast input stream; a per-pixel scoreboard checks the selected one.
module tb_maxpool_2x2_stream;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        vin = 1'b0;
  logic [15:0] din = '0;

  always #5 CLK = ~CLK;

  maxpool_2x2_stream_if #(.Datawidth(16)) bus44 ();
  maxpool_2x2_stream_if #(.Datawidth(16)) bus77 ();
  maxpool_2x2_stream_if #(.Datawidth(16)) bus22s ();
  maxpool_2x2_stream_if #(.Datawidth(16)) bus22u ();

  assign bus44.Valid_IN  = vin;
  assign bus44.In        = din;
  assign bus77.Valid_IN  = vin;
  assign bus77.In        = din;
  assign bus22s.Valid_IN = vin;
  assign bus22s.In       = din;
  assign bus22u.Valid_IN = vin;
  assign bus22u.In       = din;

  maxpool_2x2_stream #(.IMG_Width(4), .IMG_Height(4), .Datawidth(16), .Signed(1'b0)) u_dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus44.slave)
  );
  maxpool_2x2_stream #(.IMG_Width(7), .IMG_Height(7), .Datawidth(16), .Signed(1'b0)) u_dut77 (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus77.slave)
  );
  maxpool_2x2_stream #(.IMG_Width(2), .IMG_Height(2), .Datawidth(16), .Signed(1'b1)) u_dut22s (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus22s.slave)
  );
  maxpool_2x2_stream #(.IMG_Width(2), .IMG_Height(2), .Datawidth(16), .Signed(1'b0)) u_dut22u (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus22u.slave)
  );

  int          sel = 0;
  logic        obs_valid, obs_done;
  logic [15:0] obs_out;

  always_comb begin
    obs_valid = bus44.Valid_OUT;
    obs_done  = bus44.Frame_Done;
    obs_out   = bus44.Out;
    case (sel)
      1: begin obs_valid = bus77.Valid_OUT;  obs_done = bus77.Frame_Done;  obs_out = bus77.Out;  end
      2: begin obs_valid = bus22s.Valid_OUT; obs_done = bus22s.Frame_Done; obs_out = bus22s.Out; end
      3: begin obs_valid = bus22u.Valid_OUT; obs_done = bus22u.Frame_Done; obs_out = bus22u.Out; end
      default: ;
    endcase
  end

  typedef struct packed {
    logic [15:0] data;
    logic        done;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] stim_q[$];
  logic [15:0] got_q[$];
  logic [15:0] want_q[$];
  logic [15:0] img [7][7];
  logic [15:0] last_out = '0;
  int          total = 0;
  int          bad = 0;
  int          n_pulse = 0;
  int          n_done = 0;

  function automatic logic [15:0] bmax(logic [15:0] a, logic [15:0] b, bit sgn);
    if (sgn) return ($signed(a) > $signed(b)) ? a : b;
    return (a > b) ? a : b;
  endfunction

  task automatic apply_reset();
    vin = 1'b0;
    din = '0;
    CLR = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    exp_q.delete();
    got_q.delete();
    stim_q.delete();
    last_out = '0;
    n_pulse  = 0;
    n_done   = 0;
    @(posedge CLK);
    #1;
  endtask

  // Drives n_pix pixels from stim_q; the model pushes each window result as the
  // bottom-right pixel is driven, and it must appear right after that edge.
  task automatic run_frame(input int w, input int h, input bit sgn, input int n_pix,
                           input int idle_pct);
    int   i, idles, k, r, c;
    exp_t e;
    i = 0;
    idles = 0;
    while (i < n_pix) begin
      if (idle_pct > 0 && idles < 400 && int'($urandom_range(99)) < idle_pct) begin
        vin = 1'b0;
        din = 16'($urandom);
        idles++;
      end else begin
        k = i % (w * h);
        r = k / w;
        c = k % w;
        din = stim_q.pop_front();
        vin = 1'b1;
        img[r][c] = din;
        if (r % 2 == 1 && c % 2 == 1 && r < 2 * (h / 2) && c < 2 * (w / 2)) begin
          e.data = bmax(bmax(img[r-1][c-1], img[r-1][c], sgn), bmax(img[r][c-1], din, sgn), sgn);
          e.done = (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
          exp_q.push_back(e);
        end
        i++;
      end
      @(posedge CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        total++;
        if (obs_valid !== 1'b1 || obs_out !== e.data) begin
          bad++;
          $display("FAIL pulse: got valid=%b out=%h, required valid=1 out=%h", obs_valid,
                   obs_out, e.data);
        end
        total++;
        if (obs_done !== e.done) begin
          bad++;
          $display("FAIL frame_done: got %b, required %b (out=%h)", obs_done, e.done, e.data);
        end
        last_out = e.data;
      end else begin
        total++;
        if (obs_valid !== 1'b0 || obs_done !== 1'b0 || obs_out !== last_out) begin
          bad++;
          $display("FAIL quiet: got valid=%b done=%b out=%h, required 0 0 %h", obs_valid,
                   obs_done, obs_out, last_out);
        end
      end
      if (obs_valid === 1'b1) begin
        n_pulse++;
        got_q.push_back(obs_out);
      end
      if (obs_done === 1'b1) n_done++;
    end
    vin = 1'b0;
  endtask

  task automatic test_reset();
    #7;
    total++;
    if ({bus44.Valid_OUT, bus44.Frame_Done, bus44.Out} !== 18'd0) begin
      bad++;
      $display("FAIL reset_4x4: got %b %b %h, required 0 0 0000", bus44.Valid_OUT,
               bus44.Frame_Done, bus44.Out);
    end
    total++;
    if ({bus77.Valid_OUT, bus77.Frame_Done, bus77.Out} !== 18'd0) begin
      bad++;
      $display("FAIL reset_7x7: got %b %b %h, required 0 0 0000", bus77.Valid_OUT,
               bus77.Frame_Done, bus77.Out);
    end
    total++;
    if ({bus22s.Valid_OUT, bus22s.Frame_Done, bus22s.Out} !== 18'd0) begin
      bad++;
      $display("FAIL reset_2x2s: got %b %b %h, required 0 0 0000", bus22s.Valid_OUT,
               bus22s.Frame_Done, bus22s.Out);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    apply_reset();
    sel = 0;
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i));
    run_frame(4, 4, 1'b0, 16, 0);
    want_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    total++;
    if (got_q.size() != want_q.size()) begin
      bad++;
      $display("FAIL basic_count: got %0d pulses, required %0d", got_q.size(), want_q.size());
    end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      total++;
      if (got_q[i] !== want_q[i]) begin
        bad++;
        $display("FAIL basic_out[%0d]: got %h, required %h", i, got_q[i], want_q[i]);
      end
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL basic_done_count: got %0d, required 1", n_done);
    end
  endtask

  task automatic test_idle();
    apply_reset();
    sel = 0;
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i));
    run_frame(4, 4, 1'b0, 16, 50);
    repeat (3) begin
      @(posedge CLK);
      #1;
      total++;
      if (obs_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_tail: got valid=%b, required 0", obs_valid);
      end
    end
    want_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    total++;
    if (got_q.size() != want_q.size()) begin
      bad++;
      $display("FAIL idle_count: got %0d pulses, required %0d", got_q.size(), want_q.size());
    end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      total++;
      if (got_q[i] !== want_q[i]) begin
        bad++;
        $display("FAIL idle_out[%0d]: got %h, required %h", i, got_q[i], want_q[i]);
      end
    end
  endtask

  task automatic test_7x7();
    apply_reset();
    sel = 1;
    for (int r = 0; r < 7; r++) for (int c = 0; c < 7; c++) stim_q.push_back(16'(r * 7 + c));
    run_frame(7, 7, 1'b0, 49, 0);
    want_q = '{16'd8, 16'd10, 16'd12, 16'd22, 16'd24, 16'd26, 16'd36, 16'd38, 16'd40};
    total++;
    if (got_q.size() != want_q.size()) begin
      bad++;
      $display("FAIL odd_count: got %0d pulses, required %0d", got_q.size(), want_q.size());
    end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      total++;
      if (got_q[i] !== want_q[i]) begin
        bad++;
        $display("FAIL odd_out[%0d]: got %h, required %h", i, got_q[i], want_q[i]);
      end
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL odd_done_count: got %0d, required 1", n_done);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    sel = 0;
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i));
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(15 - i));
    run_frame(4, 4, 1'b0, 32, 0);
    want_q = '{16'd5, 16'd7, 16'd13, 16'd15, 16'd15, 16'd13, 16'd7, 16'd5};
    total++;
    if (got_q.size() != want_q.size()) begin
      bad++;
      $display("FAIL b2b_count: got %0d pulses, required %0d", got_q.size(), want_q.size());
    end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      total++;
      if (got_q[i] !== want_q[i]) begin
        bad++;
        $display("FAIL b2b_out[%0d]: got %h, required %h", i, got_q[i], want_q[i]);
      end
    end
    total++;
    if (n_done != 2) begin
      bad++;
      $display("FAIL b2b_done_count: got %0d, required 2", n_done);
    end
  endtask

  task automatic test_signed();
    logic [15:0] neg[4];
    logic [15:0] pos[4];
    logic [15:0] want[4];
    neg = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'hFFFE};
    pos = '{16'h0001, 16'h0002, 16'h0003, 16'h8000};
    // sel 2 = signed, sel 3 = unsigned; rows: neg/signed, pos/signed, neg/unsigned, pos/unsigned
    want = '{16'hFFFF, 16'h0003, 16'hFFFF, 16'h8000};
    for (int t = 0; t < 4; t++) begin
      apply_reset();
      sel = (t < 2) ? 2 : 3;
      for (int i = 0; i < 4; i++) stim_q.push_back((t % 2 == 0) ? neg[i] : pos[i]);
      run_frame(2, 2, (t < 2), 4, 0);
      total++;
      if (got_q.size() != 1 || got_q[0] !== want[t]) begin
        bad++;
        $display("FAIL cmp_case%0d: got %0d pulses first=%h, required 1 pulse %h", t,
                 got_q.size(), (got_q.size() != 0) ? got_q[0] : 16'hxxxx, want[t]);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    sel = 0;
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i));
    run_frame(4, 4, 1'b0, 6, 0);
    #2;
    CLR = 1'b1;
    #1;
    total++;
    if (obs_valid !== 1'b0 || obs_done !== 1'b0 || obs_out !== 16'h0000) begin
      bad++;
      $display("FAIL async_clr: got valid=%b done=%b out=%h, required 0 0 0000", obs_valid,
               obs_done, obs_out);
    end
    // Pixels offered while CLR is high must be ignored.
    vin = 1'b1;
    din = 16'h7777;
    @(posedge CLK);
    #1;
    vin = 1'b0;
    total++;
    if (obs_valid !== 1'b0 || obs_done !== 1'b0 || obs_out !== 16'h0000) begin
      bad++;
      $display("FAIL clr_hold: got valid=%b done=%b out=%h, required 0 0 0000", obs_valid,
               obs_done, obs_out);
    end
    @(negedge CLK);
    CLR = 1'b0;
    stim_q.delete();
    exp_q.delete();
    got_q.delete();
    last_out = '0;
    n_done   = 0;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 16; i++) stim_q.push_back(16'(i));
    run_frame(4, 4, 1'b0, 16, 0);
    want_q = '{16'd5, 16'd7, 16'd13, 16'd15};
    total++;
    if (got_q.size() != want_q.size()) begin
      bad++;
      $display("FAIL clr_count: got %0d pulses, required %0d", got_q.size(), want_q.size());
    end
    for (int i = 0; i < got_q.size() && i < want_q.size(); i++) begin
      total++;
      if (got_q[i] !== want_q[i]) begin
        bad++;
        $display("FAIL clr_out[%0d]: got %h, required %h", i, got_q[i], want_q[i]);
      end
    end
    total++;
    if (n_done != 1) begin
      bad++;
      $display("FAIL clr_done_count: got %0d, required 1", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_idle();
    test_7x7();
    test_back_to_back();
    test_signed();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
